// File: rtl/sm83_fetch.sv
// SM83 instruction fetch stage: opcode read at PC, IR latch, CB-prefix folding and overlapped fetch.
// Optional macro SM83_CB_PREFIX_EN enables the FETCH_CB state; without it 0xCB issues as a plain opcode.
module sm83_fetch #(
    parameter logic [7:0] RESET_IR = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic [7:0]  mem_d,
    input  logic        stall,
    input  logic        seq_done,
    input  logic        halt_req,
    input  logic        wake,
    output logic        fetch_rd,
    output logic [15:0] fetch_addr,
    output logic        pc_inc,
    output logic [7:0]  ir,
    output logic        ir_cb,
    output logic        ir_valid,
    output logic        issue
);

`ifdef SM83_CB_PREFIX_EN
    typedef enum logic [1:0] {FETCH = 2'd0, FETCH_CB = 2'd1, EXEC = 2'd2, HALTED = 2'd3} state_t;
`else
    typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd2, HALTED = 2'd3} state_t;
`endif

    state_t state, state_next;
    logic   take;
    logic   prefix_byte;
    logic   second_byte;
    logic   halt_enter;

    assign fetch_addr = pc;

    always_comb begin
        state_next  = state;
        fetch_rd    = 1'b0;
        second_byte = 1'b0;
        halt_enter  = 1'b0;
        unique case (state)
            FETCH:    fetch_rd = 1'b1;
`ifdef SM83_CB_PREFIX_EN
            FETCH_CB: begin
                fetch_rd    = 1'b1;
                second_byte = 1'b1;
            end
`endif
            EXEC: begin
                fetch_rd   = seq_done & ~halt_req;
                halt_enter = seq_done & halt_req;
            end
            HALTED:   fetch_rd = 1'b0;
            default:  fetch_rd = 1'b0;
        endcase
        if (rst) begin
            fetch_rd   = 1'b0;
            halt_enter = 1'b0;
        end

        take   = fetch_rd & ~stall;
        pc_inc = take;
`ifdef SM83_CB_PREFIX_EN
        prefix_byte = ~second_byte & (mem_d == 8'hCB);
`else
        prefix_byte = 1'b0;
`endif

        // A prefix byte parks in FETCH_CB; anything else (including the CB-page byte) starts execution.
        if (take) begin
`ifdef SM83_CB_PREFIX_EN
            state_next = prefix_byte ? FETCH_CB : EXEC;
`else
            state_next = EXEC;
`endif
        end else if (halt_enter) begin
            state_next = HALTED;
        end else if (state == HALTED && wake) begin
            state_next = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            ir       <= RESET_IR;
            ir_valid <= 1'b0;
            issue    <= 1'b0;
        end else begin
            state <= state_next;
            issue <= 1'b0;
            if (take) begin
                ir       <= mem_d;
                ir_valid <= ~prefix_byte;
                issue    <= ~prefix_byte;
            end else if (halt_enter) begin
                ir_valid <= 1'b0;
            end
        end
    end

`ifdef SM83_CB_PREFIX_EN
    logic ir_cb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_cb_q <= 1'b0;
        end else if (take) begin
            ir_cb_q <= second_byte;
        end
    end

    assign ir_cb = ir_cb_q;
`else
    assign ir_cb = 1'b0;
`endif

endmodule

// File: doc/sm83_fetch.md
# sm83_fetch

Instruction fetch stage of the SM83 core, directly upstream of the sequencer and decoder. It drives the opcode read at PC, requests the PC increment, and latches the opcode into the instruction register (IR). It folds the 0xCB prefix into a flag and overlaps the next fetch with the last M-cycle of the current instruction. One clk edge equals one M-cycle.

## Interface
Parameters:
- RESET_IR, 8'h00: IR value after reset (NOP).

Ports:
- clk  in  1  core clock, one M-cycle per edge
- rst  in  1  reset; synchronous, active-high
- pc  in  16  current PC from the register file
- mem_d  in  8  memory read data (same byte the core sees as d_in)
- stall  in  1  memory not ready this M-cycle
- seq_done  in  1  sequencer is in the final M-cycle of the current instruction
- halt_req  in  1  current instruction is HALT (qualified by seq_done)
- wake  in  1  pending interrupt; releases HALTED
- fetch_rd  out  1  opcode read request this M-cycle
- fetch_addr  out  16  read address; always equals pc
- pc_inc  out  1  IDU request: PC <- PC + 1 at this edge
- ir  out  8  instruction register to sequencer/decoder
- ir_cb  out  1  ir is a CB-page opcode
- ir_valid  out  1  ir holds an issuable instruction
- issue  out  1  one-cycle pulse: new instruction entered ir this cycle

## Operation
- States: FETCH, FETCH_CB, EXEC, HALTED. Reset state is FETCH.
- Outputs are decoded combinationally from state and inputs. Define `take` = fetch_rd & ~stall.
- FETCH:
  - fetch_rd=1 and pc_inc=take.
  - On take, ir<=mem_d and ir_cb<=0.
  - If mem_d==8'hCB, go to FETCH_CB with ir_valid<=0. Otherwise go to EXEC with ir_valid<=1 and issue<=1.
- FETCH_CB:
  - fetch_rd=1 and pc_inc=take.
  - On take, ir<=mem_d, ir_cb<=1, ir_valid<=1, issue<=1, then go to EXEC.
  - A second 0xCB byte here is a plain CB-page opcode (CB CB = SET 1,E).
- EXEC:
  - With seq_done=0: fetch_rd=0, pc_inc=0, ir is held.
  - With seq_done=1 and halt_req=0, fetch overlaps: fetch_rd=1 and pc_inc=take. On take the latch behaves exactly as in FETCH, including the CB detect. There is no bubble between instructions.
  - With seq_done=1 and halt_req=1: fetch_rd=0, pc_inc=0. Go to HALTED with ir_valid<=0.
- HALTED:
  - fetch_rd=0 and pc_inc=0.
  - wake=1 moves to FETCH at the next edge. wake has no effect in any other state.
- issue is registered and high for exactly one cycle per accepted non-prefix byte. Otherwise it is 0.

## Timing
- Reset, while rst=1:
  - fetch_rd=0, pc_inc=0, fetch_addr=pc.
  - After the edge: ir=RESET_IR, ir_cb=0, ir_valid=0, issue=0, state=FETCH.
  - rst overrides every other input.
- Fetch-to-issue latency:
  - Plain opcode: 1 cycle, i.e. ir and issue are valid on the edge after the fetch M-cycle.
  - CB opcode: 2 cycles.
- stall=1: pc_inc=0, fetch_rd stays asserted, state and ir are held, issue=0. The sequencer holds seq_done high for as long as stall persists.
- halt_req without seq_done is ignored. halt_req and wake in the same cycle: HALT is taken, and wake is acted on in the next cycle.
- Reset in FETCH_CB discards the prefix: ir_cb=0 and the next fetch restarts at pc.
- PC wrap 16'hFFFF->16'h0000 belongs to the IDU; fetch_addr simply follows pc.

## Configuration
- SM83_CB_PREFIX_EN defined:
  - The FETCH_CB state exists and behaves as above.
- SM83_CB_PREFIX_EN undefined:
  - The FETCH_CB state is removed.
  - 8'hCB is latched and issued as an ordinary opcode with 1-cycle latency.
  - ir_cb is tied to 0.

## Test plan
- Reset start: release rst with pc=16'h0100 and mem_d=8'h00. The first cycle shows fetch_addr=16'h0100, fetch_rd=1, pc_inc=1. At the next edge: ir=8'h00, ir_valid=1, issue=1 for one cycle.
- CB prefix (macro on): feed mem_d=8'hCB, then 8'h37. Required: ir_valid=0 for one cycle, pc_inc=1 in both cycles, then ir=8'h37, ir_cb=1, issue=1. With the macro off: ir=8'hCB, ir_cb=0 after one cycle.
- Overlap: in EXEC assert seq_done with mem_d=8'h41. At the next edge ir=8'h41, ir_valid stays 1, issue=1, and there is no cycle with ir_valid=0.
- Stall: in FETCH hold stall=1 for 2 cycles with mem_d=8'h3E. Required: pc_inc=0, ir unchanged, issue=0. Then stall=0 gives ir=8'h3E and issue=1.
- Halt: seq_done=1 and halt_req=1 give fetch_rd=0 and ir_valid=0 for 5 idle cycles. wake=1 then gives fetch_rd=1 at fetch_addr=pc on the following cycle.
- Reset mid-prefix: assert rst in FETCH_CB. Required: ir=8'h00, ir_cb=0, ir_valid=0, and the next fetch is a plain opcode.
